// File: rtl/stopwatch_if.sv
// Bundle of button pulses, counter-chain BCD input and display/control
// outputs exchanged between the stopwatch controller and its surroundings.
// Signalling: there is no valid/ready handshake here. Every btn_* input is a
// single-cycle pulse that is acted on in the clk cycle it is high. cnt_en and
// cnt_grst are single-cycle pulses to the counter chain. All other signals
// are levels.
interface stopwatch_if;
    logic        btn_ss;
    logic        btn_clr;
    logic        btn_lap;
    logic [15:0] digits_in;
    logic        cnt_en;
    logic        cnt_grst;
    logic [3:0]  an;
    logic [3:0]  bcd_out;
    logic        dp;
    logic [1:0]  state;

    // Surroundings: drive buttons and counter digits, observe controller outputs.
    modport master (
        output btn_ss, btn_clr, btn_lap, digits_in,
        input  cnt_en, cnt_grst, an, bcd_out, dp, state
    );

    // Controller side.
    modport slave (
        input  btn_ss, btn_clr, btn_lap, digits_in,
        output cnt_en, cnt_grst, an, bcd_out, dp, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for a four-digit cascaded BCD stopwatch, plus
// a free-running scanner that multiplexes the digits onto active-low anodes.
// Optional lap freeze of the displayed value: define LAP_HOLD_EN.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic         clk,
    input  logic         grst_n,
    stopwatch_if.slave   sw
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FULL  = 2'd3
    } sw_state_e;

    sw_state_e     state_q, state_nxt;
    logic [TW-1:0] tick_cnt, tick_cnt_nxt;
    logic          en_nxt;
    logic          grst_nxt;
    logic          clr_ok;
    logic          terminal;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [15:0]   src;

    // Clear is honoured everywhere except RUN.
    assign clr_ok   = sw.btn_clr && (state_q != RUN);
    assign terminal = (tick_cnt == TW'(TICK_DIV - 1));

    // Next-state, prescaler and counter-chain pulse decode.
    always_comb begin
        state_nxt    = state_q;
        tick_cnt_nxt = tick_cnt;
        en_nxt       = 1'b0;
        grst_nxt     = 1'b0;
        case (state_q)
            IDLE: begin
                tick_cnt_nxt = '0;
                if (clr_ok) begin
                    grst_nxt = 1'b1;
                end else if (sw.btn_ss) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (sw.btn_ss) begin
                    // Pause holds the prescaler so the resume continues the tick phase.
                    state_nxt = PAUSE;
                end else if (terminal) begin
                    tick_cnt_nxt = '0;
                    if (sw.digits_in == 16'h9999) begin
                        // Stop at 99.99 instead of letting the chain wrap to 00.00.
                        state_nxt = FULL;
                    end else begin
                        en_nxt = 1'b1;
                    end
                end else begin
                    tick_cnt_nxt = tick_cnt + 1'b1;
                end
            end
            PAUSE: begin
                if (clr_ok) begin
                    grst_nxt     = 1'b1;
                    tick_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end else if (sw.btn_ss) begin
                    state_nxt = RUN;
                end
            end
            FULL: begin
                if (clr_ok) begin
                    grst_nxt     = 1'b1;
                    tick_cnt_nxt = '0;
                    state_nxt    = IDLE;
                end
            end
            default: begin
                state_nxt    = IDLE;
                tick_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state, prescaler and registered counter-chain pulses.
    always_ff @(posedge clk or negedge grst_n) begin
        if (!grst_n) begin
            state_q     <= IDLE;
            tick_cnt    <= '0;
            sw.cnt_en   <= 1'b0;
            sw.cnt_grst <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            tick_cnt    <= tick_cnt_nxt;
            sw.cnt_en   <= en_nxt;
            sw.cnt_grst <= grst_nxt;
        end
    end

    assign sw.state = state_q;

`ifdef LAP_HOLD_EN
    logic [15:0] lap_q;
    logic        freeze_q;

    // Lap capture: first press in RUN freezes the display, any next press releases it.
    always_ff @(posedge clk or negedge grst_n) begin
        if (!grst_n) begin
            lap_q    <= '0;
            freeze_q <= 1'b0;
        end else if (clr_ok) begin
            freeze_q <= 1'b0;
        end else if (sw.btn_lap) begin
            if (freeze_q) begin
                freeze_q <= 1'b0;
            end else if (state_q == RUN) begin
                lap_q    <= sw.digits_in;
                freeze_q <= 1'b1;
            end
        end
    end

    assign src = freeze_q ? lap_q : sw.digits_in;
`else
    logic unused_lap;
    assign unused_lap = sw.btn_lap;
    assign src        = sw.digits_in;
`endif

    // Free-running digit scanner with registered anode/BCD/dp outputs.
    always_ff @(posedge clk or negedge grst_n) begin
        if (!grst_n) begin
            scan_cnt   <= '0;
            idx        <= 2'd0;
            sw.an      <= 4'b1111;
            sw.bcd_out <= 4'd0;
            sw.dp      <= 1'b1;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            sw.an      <= ~(4'b0001 << idx);
            sw.bcd_out <= src[{idx, 2'b00} +: 4];
            sw.dp      <= (idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, SCAN_DIV=2.
// Cycle numbers count rising edges after reset release; an input raised
// before edge n is sampled at edge n, outputs are sampled 1 ns after edges.
module tb_stopwatch_ctrl;

    logic clk;
    logic grst_n;
    int   cyc;
    int   checks;
    int   errors;

    stopwatch_if sw ();

    stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk    (clk),
        .grst_n (grst_n),
        .sw     (sw)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        grst_n       = 1'b0;
        sw.btn_ss    = 1'b0;
        sw.btn_clr   = 1'b0;
        sw.btn_lap   = 1'b0;
        sw.digits_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        grst_n = 1'b1;
        cyc    = 0;
    endtask

    // Raise the given buttons so they are sampled at edge n.
    task automatic press(input int n, input logic ss, input logic clr, input logic lap);
        step_to(n - 1);
        sw.btn_ss  = ss;
        sw.btn_clr = clr;
        sw.btn_lap = lap;
        step();
        sw.btn_ss  = 1'b0;
        sw.btn_clr = 1'b0;
        sw.btn_lap = 1'b0;
    endtask

    // Collect the four displayed digits over one full scan round.
    task automatic read_display(output logic [15:0] val);
        val = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            step();
            case (sw.an)
                4'b1110: val[3:0]   = sw.bcd_out;
                4'b1101: val[7:4]   = sw.bcd_out;
                4'b1011: val[11:8]  = sw.bcd_out;
                4'b0111: val[15:12] = sw.bcd_out;
                default: val = 16'hxxxx;
            endcase
        end
    endtask

    logic [8:0] exp_q[$];

    initial begin
        logic [8:0]  e;
        logic [15:0] disp;
        checks = 0;
        errors = 0;
        cyc    = 0;

        // Reset values and tick cadence
        do_reset();
        check("rst_state", sw.state, 0);
        check("rst_an", sw.an, 4'b1111);
        check("rst_bcd", sw.bcd_out, 0);
        check("rst_dp", sw.dp, 1);
        check("rst_en", sw.cnt_en, 0);
        check("rst_grst", sw.cnt_grst, 0);
        press(10, 1, 0, 0);
        check("run_state", sw.state, 1);
        while (cyc < 22) begin
            step();
            check("tick_en", sw.cnt_en, (cyc == 14 || cyc == 18 || cyc == 22) ? 1 : 0);
        end
        // Asynchronous reset while a tick is high
        grst_n = 1'b0;
        #1;
        check("async_en", sw.cnt_en, 0);
        check("async_state", sw.state, 0);
        check("async_an", sw.an, 4'b1111);

        // Pause holds the prescaler, resume keeps the phase; clear rules
        do_reset();
        press(10, 1, 0, 0);
        press(16, 1, 0, 0);
        check("pause_state", sw.state, 2);
        while (cyc < 29) begin
            step();
            check("pause_en", sw.cnt_en, 0);
        end
        press(30, 1, 0, 0);
        check("resume_state", sw.state, 1);
        check("resume_en30", sw.cnt_en, 0);
        while (cyc < 33) begin
            step();
            check("resume_en", sw.cnt_en, (cyc == 33) ? 1 : 0);
        end
        press(36, 1, 0, 0);
        press(38, 0, 1, 0);
        check("clr_grst", sw.cnt_grst, 1);
        check("clr_state", sw.state, 0);
        check("clr_en", sw.cnt_en, 0);
        step();
        check("clr_grst_off", sw.cnt_grst, 0);
        press(40, 1, 0, 0);
        press(41, 0, 1, 0);
        check("runclr_grst", sw.cnt_grst, 0);
        check("runclr_state", sw.state, 1);
        press(42, 1, 0, 0);
        press(43, 1, 1, 0);
        check("both_pause_state", sw.state, 0);
        check("both_pause_grst", sw.cnt_grst, 1);
        press(44, 1, 1, 0);
        check("both_idle_state", sw.state, 0);
        check("both_idle_grst", sw.cnt_grst, 1);
        press(45, 1, 0, 0);
        press(46, 1, 1, 0);
        check("both_run_state", sw.state, 2);
        check("both_run_grst", sw.cnt_grst, 0);

        // Saturation at 99.99
        do_reset();
        sw.digits_in = 16'h9999;
        press(10, 1, 0, 0);
        while (cyc < 18) begin
            step();
            check("full_en", sw.cnt_en, 0);
            check("full_state", sw.state, (cyc >= 14) ? 3 : 1);
        end
        press(20, 1, 0, 0);
        check("full_ss_ign", sw.state, 3);
        press(22, 0, 1, 0);
        check("full_clr_state", sw.state, 0);
        check("full_clr_grst", sw.cnt_grst, 1);

        // Digit scan sequence from reset, digits 4321
        do_reset();
        sw.digits_in = 16'h4321;
        exp_q = {};
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back({4'b1110, 4'd1, 1'b1});
            exp_q.push_back({4'b1101, 4'd2, 1'b1});
            exp_q.push_back({4'b1011, 4'd3, 1'b0});
            exp_q.push_back({4'b0111, 4'd4, 1'b1});
        end
        exp_q = exp_q[0:8];
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            check("scan_a", {sw.an, sw.bcd_out, sw.dp}, e);
            step();
            check("scan_b", {sw.an, sw.bcd_out, sw.dp}, e);
        end
        read_display(disp);
        check("scan_word", disp, 16'h4321);

`ifdef LAP_HOLD_EN
        // Lap freeze and release
        do_reset();
        sw.digits_in = 16'h0123;
        press(10, 1, 0, 0);
        press(12, 0, 0, 1);
        sw.digits_in = 16'h0456;
        read_display(disp);
        check("lap_frozen", disp, 16'h0123);
        check("lap_state", sw.state, 1);
        press(cyc + 1, 0, 0, 1);
        read_display(disp);
        check("lap_released", disp, 16'h0456);
        press(cyc + 1, 1, 0, 0);
        press(cyc + 1, 0, 0, 1);
        sw.digits_in = 16'h0789;
        read_display(disp);
        check("lap_pause_ign", disp, 16'h0789);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
